// File: rtl/zero_rle_packer_pkg.sv
// Shared types and code constants for the zero-run-length packer.
// Contents: FSM state enum, datapath widths, byte-code tags and literal range.
package zero_rle_packer_pkg;

  localparam int unsigned COEF_W = 9;   // signed coefficient width
  localparam int unsigned BYTE_W = 8;   // output code width
  localparam int unsigned CNT_W  = 18;  // byte_count width
  localparam int unsigned RUN_W  = 6;   // run byte length field, holds n-1

  typedef enum logic [2:0] {
    S_ACC,
    S_LIT,
    S_ESC_LO,
    S_FLUSH,
    S_EOB
  } state_e;

  localparam logic [1:0]               RUN_TAG  = 2'b10;
  localparam logic [6:0]               ESC_TAG  = 7'b1100000;
  localparam logic [BYTE_W-1:0]        EOB_CODE = 8'hFF;
  localparam logic signed [COEF_W-1:0] LIT_MIN  = -9'sd64;
  localparam logic signed [COEF_W-1:0] LIT_MAX  = 9'sd63;

endpackage

// File: rtl/zero_rle_packer_if.sv
// Stream interface of the zero-run-length packer.
// Input side: in_coef/in_valid/in_last from the wavelet datapath, in_ready back.
// Output side: out_data/out_write to the coded byte store, done pulse, byte_count.
// Modports: master = upstream/store side, slave = packer.
interface zero_rle_packer_if
  import zero_rle_packer_pkg::*;
();

  logic signed [COEF_W-1:0] in_coef;
  logic                     in_valid;
  logic                     in_last;
  logic                     in_ready;
  logic [BYTE_W-1:0]        out_data;
  logic                     out_write;
  logic                     done;
  logic [CNT_W-1:0]         byte_count;

  modport master (
    output in_coef, in_valid, in_last,
    input  in_ready, out_data, out_write, done, byte_count
  );

  modport slave (
    input  in_coef, in_valid, in_last,
    output in_ready, out_data, out_write, done, byte_count
  );

endinterface

// File: rtl/zrle_code_format.sv
// Combinational coefficient-to-code mapper.
// coef_i        : signed coefficient (caller guarantees nonzero when used)
// is_literal_o  : coefficient fits the 7-bit signed literal code
// first_byte_o  : literal byte, or escape byte 1100000s carrying the sign bit
// second_byte_o : low byte coef[7:0], only meaningful after an escape
module zrle_code_format
  import zero_rle_packer_pkg::*;
(
  input  logic signed [COEF_W-1:0] coef_i,
  output logic                     is_literal_o,
  output logic [BYTE_W-1:0]        first_byte_o,
  output logic [BYTE_W-1:0]        second_byte_o
);

  always_comb begin
    is_literal_o  = (coef_i >= LIT_MIN) && (coef_i <= LIT_MAX);
    first_byte_o  = is_literal_o ? {1'b0, coef_i[6:0]} : {ESC_TAG, coef_i[8]};
    second_byte_o = coef_i[7:0];
  end

endmodule

// File: rtl/zero_rle_packer.sv
// Zero-run-length packer: turns 9-bit signed coefficients into a byte stream of
// literal (0vvvvvvv), run (10nnnnnn, n+1 zeros), escape (1100000s + low byte)
// and EOB (0xFF) codes. One byte per cycle at most, no output backpressure.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : zero_rle_packer_if.slave (coefficient input, byte output, done, byte_count)
// Build option: define ZRLE_BYTE_COUNT_EN to get a saturating emitted-byte counter
// on byte_count; otherwise byte_count is tied to zero.
module zero_rle_packer
  import zero_rle_packer_pkg::*;
#(
  parameter int unsigned RUN_MAX = 64  // 1..64
) (
  input logic               clk,
  input logic               rst,
  zero_rle_packer_if.slave  bus
);

  localparam logic [RUN_W:0]   RunMaxC  = (RUN_W+1)'(RUN_MAX);
  localparam logic [RUN_W-1:0] RunMaxM1 = RUN_W'(RUN_MAX - 1);

  state_e                   state_q;
  logic [RUN_W-1:0]         run_cnt_q;
  logic signed [COEF_W-1:0] coef_q;
  logic                     last_q;
  logic [BYTE_W-1:0]        out_data_q;
  logic                     out_write_q;
  logic                     done_q;

  logic signed [COEF_W-1:0] fmt_coef;
  logic                     is_literal;
  logic [BYTE_W-1:0]        first_byte;
  logic [BYTE_W-1:0]        second_byte;
  logic [RUN_W:0]           cnt_inc;
  logic [RUN_W-1:0]         run_m1;
  logic                     coef_is_zero;

  // Only S_ACC looks at the live input; every other state formats the held coefficient.
  assign fmt_coef     = (state_q == S_ACC) ? bus.in_coef : coef_q;
  assign cnt_inc      = {1'b0, run_cnt_q} + (RUN_W+1)'(1);
  assign run_m1       = run_cnt_q - RUN_W'(1);
  assign coef_is_zero = (bus.in_coef == '0);

  zrle_code_format u_fmt (
    .coef_i        (fmt_coef),
    .is_literal_o  (is_literal),
    .first_byte_o  (first_byte),
    .second_byte_o (second_byte)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_ACC;
      run_cnt_q   <= '0;
      coef_q      <= '0;
      last_q      <= 1'b0;
      out_data_q  <= '0;
      out_write_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      out_write_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        S_ACC: begin
          if (bus.in_valid) begin
            if (coef_is_zero) begin
              // A full run is flushed on the same edge that completes it.
              if (cnt_inc == RunMaxC) begin
                out_data_q  <= {RUN_TAG, RunMaxM1};
                out_write_q <= 1'b1;
                run_cnt_q   <= '0;
              end else begin
                run_cnt_q <= cnt_inc[RUN_W-1:0];
              end
              if (bus.in_last) state_q <= S_FLUSH;
            end else if (run_cnt_q == '0) begin
              out_data_q  <= first_byte;
              out_write_q <= 1'b1;
              if (is_literal) begin
                state_q <= bus.in_last ? S_FLUSH : S_ACC;
              end else begin
                coef_q  <= bus.in_coef;
                last_q  <= bus.in_last;
                state_q <= S_ESC_LO;
              end
            end else begin
              // Pending run goes out first; the coefficient waits in coef_q.
              out_data_q  <= {RUN_TAG, run_m1};
              out_write_q <= 1'b1;
              run_cnt_q   <= '0;
              coef_q      <= bus.in_coef;
              last_q      <= bus.in_last;
              state_q     <= S_LIT;
            end
          end
        end
        S_LIT: begin
          out_data_q  <= first_byte;
          out_write_q <= 1'b1;
          if (is_literal) state_q <= last_q ? S_FLUSH : S_ACC;
          else            state_q <= S_ESC_LO;
        end
        S_ESC_LO: begin
          out_data_q  <= second_byte;
          out_write_q <= 1'b1;
          state_q     <= last_q ? S_FLUSH : S_ACC;
        end
        S_FLUSH: begin
          if (run_cnt_q != '0) begin
            out_data_q  <= {RUN_TAG, run_m1};
            out_write_q <= 1'b1;
          end
          run_cnt_q <= '0;
          state_q   <= S_EOB;
        end
        S_EOB: begin
          out_data_q  <= EOB_CODE;
          out_write_q <= 1'b1;
          done_q      <= 1'b1;
          run_cnt_q   <= '0;
          last_q      <= 1'b0;
          state_q     <= S_ACC;
        end
        default: state_q <= S_ACC;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == S_ACC);
  assign bus.out_data  = out_data_q;
  assign bus.out_write = out_write_q;
  assign bus.done      = done_q;

`ifdef ZRLE_BYTE_COUNT_EN
  logic [CNT_W-1:0] byte_count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_count_q <= '0;
    end else if (out_write_q && (byte_count_q != '1)) begin
      byte_count_q <= byte_count_q + CNT_W'(1);
    end
  end

  assign bus.byte_count = byte_count_q;
`else
  assign bus.byte_count = '0;
`endif

endmodule
